mem_arbiter: RTL and testbench

//  Shares the single data-memory port between instruction fetch (IF) and load/store (LS) requesters.

---
 rtl/mem_arbiter_if.sv | 41 ++++
 rtl/mem_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of the IF/LS requester channels, shared response and the memory port.
// The master modport is the arbiter's view; slave is the requesters plus memory.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            if_valid;
  logic            if_ready;
  logic [AW-1:0]   if_addr;
  logic            if_rvalid;
  logic            ls_valid;
  logic            ls_ready;
  logic [AW-1:0]   ls_addr;
  logic            ls_wen;
  logic [DW-1:0]   ls_wdata;
  logic [DW/8-1:0] ls_wmask;
  logic            ls_rvalid;
  logic [DW-1:0]   resp_rdata;
  logic            mem_valid;
  logic            mem_ready;
  logic [AW-1:0]   mem_addr;
  logic            mem_wen;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_wmask;
  logic            mem_rvalid;
  logic [DW-1:0]   mem_rdata;

  modport master (
    input  if_valid, if_addr, ls_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
    input  mem_ready, mem_rvalid, mem_rdata,
    output if_ready, if_rvalid, ls_ready, ls_rvalid, resp_rdata,
    output mem_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );

  modport slave (
    output if_valid, if_addr, ls_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
    output mem_ready, mem_rvalid, mem_rdata,
    input  if_ready, if_rvalid, ls_ready, ls_rvalid, resp_rdata,
    input  mem_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one request at a time.
// LS wins ties; a starvation counter forces an IF grant after STARVE_LIM LS grants in a row.
module mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.master  bus,
  output logic           arb_busy
);
  localparam int MW = DW / 8;
  localparam int CW = $clog2(STARVE_LIM + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t          state;
  state_t          state_next;
  logic            owner_ls;
  logic            owner_ls_next;
  logic [CW-1:0]   starve_cnt;
  logic [CW-1:0]   starve_cnt_next;
  logic            starved;
  logic            grant_ls;
  logic            grant_if;
  logic [AW-1:0]   addr_q;
  logic            wen_q;
  logic [DW-1:0]   wdata_q;
  logic [MW-1:0]   wmask_q;
  logic [DW-1:0]   resp_q;
  logic            if_rvalid_q;
  logic            ls_rvalid_q;

  // Ready is held low while reset is asserted so every output reads 0 during reset.
  always_comb begin
    starved  = bus.if_valid && (starve_cnt == CW'(STARVE_LIM));
    grant_ls = (state == IDLE) && rst && bus.ls_valid && !starved;
    grant_if = (state == IDLE) && rst && bus.if_valid && !grant_ls;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner_ls   <= 1'b0;
      starve_cnt <= '0;
    end else begin
      state      <= state_next;
      owner_ls   <= owner_ls_next;
      starve_cnt <= starve_cnt_next;
    end
  end

  always_comb begin
    state_next      = state;
    owner_ls_next   = owner_ls;
    starve_cnt_next = starve_cnt;
    case (state)
      IDLE: begin
        if (grant_ls) begin
          state_next      = ISSUE;
          owner_ls_next   = 1'b1;
          starve_cnt_next = bus.if_valid ? starve_cnt + 1'b1 : '0;
        end else if (grant_if) begin
          state_next      = ISSUE;
          owner_ls_next   = 1'b0;
          starve_cnt_next = '0;
        end
      end
      ISSUE: begin
        if (bus.mem_ready) state_next = WAIT;
      end
      WAIT: begin
        if (bus.mem_rvalid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // IF requests are always reads, so their write payload is forced to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else if (grant_ls) begin
      addr_q  <= bus.ls_addr;
      wen_q   <= bus.ls_wen;
      wdata_q <= bus.ls_wdata;
      wmask_q <= bus.ls_wmask;
    end else if (grant_if) begin
      addr_q  <= bus.if_addr;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end
  end

  // A memory response outside WAIT is a protocol violation and is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_q      <= '0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
    end else begin
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if (state == WAIT && bus.mem_rvalid) begin
        resp_q <= bus.mem_rdata;
        if (owner_ls) ls_rvalid_q <= 1'b1;
        else          if_rvalid_q <= 1'b1;
      end
    end
  end

  assign bus.if_ready   = grant_if;
  assign bus.ls_ready   = grant_ls;
  assign bus.if_rvalid  = if_rvalid_q;
  assign bus.ls_rvalid  = ls_rvalid_q;
  assign bus.resp_rdata = resp_q;
  assign bus.mem_valid  = (state == ISSUE);
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wen    = wen_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.mem_wmask  = wmask_q;
  assign arb_busy       = (state != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single IF read, LS priority, starvation rotation,
// memory stall, stray response and mid-transaction reset.
module tb_mem_arbiter;
  logic clk;
  logic rst;
  logic arb_busy;
  int   testCount;
  int   failCount;

  mem_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_arbiter #(.AW(32), .DW(32), .STARVE_LIM(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .arb_busy (arb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // One clock cycle of inputs; checks after this call see the settled state of that cycle.
  task automatic applyStimulus(input logic iv, input logic [31:0] ia,
                               input logic lv, input logic [31:0] la, input logic lw,
                               input logic [31:0] wd, input logic [3:0] wm,
                               input logic mr, input logic mrv, input logic [31:0] mrd);
    @(posedge clk);
    #1;
    bus.if_valid   = iv;
    bus.if_addr    = ia;
    bus.ls_valid   = lv;
    bus.ls_addr    = la;
    bus.ls_wen     = lw;
    bus.ls_wdata   = wd;
    bus.ls_wmask   = wm;
    bus.mem_ready  = mr;
    bus.mem_rvalid = mrv;
    bus.mem_rdata  = mrd;
    #2;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctrl"}, {bus.if_ready, bus.ls_ready, bus.if_rvalid, bus.ls_rvalid,
                                 bus.mem_valid, bus.mem_wen, arb_busy}, 7'b0);
    checkOutput({tag, "_addr"}, bus.mem_addr, 32'h0);
    checkOutput({tag, "_wdata"}, bus.mem_wdata, 32'h0);
    checkOutput({tag, "_wmask"}, bus.mem_wmask, 4'h0);
    checkOutput({tag, "_resp"}, bus.resp_rdata, 32'h0);
  endtask

  initial begin
    logic expLs;
    logic prevLs;
    testCount = 0;
    failCount = 0;
    prevLs    = 1'b0;
    rst = 1'b1;
    bus.if_valid = 1'b0; bus.if_addr = '0; bus.ls_valid = 1'b0; bus.ls_addr = '0;
    bus.ls_wen = 1'b0; bus.ls_wdata = '0; bus.ls_wmask = '0;
    bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    #2 rst = 1'b0;
    #3;
    checkAllZero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // 1: IF-only read
    applyStimulus(1, 32'h80000000, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("t1_if_ready", bus.if_ready, 1'b1);
    checkOutput("t1_ls_ready", bus.ls_ready, 1'b0);
    checkOutput("t1_mem_valid_idle", bus.mem_valid, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("t1_mem_valid", bus.mem_valid, 1'b1);
    checkOutput("t1_mem_addr", bus.mem_addr, 32'h80000000);
    checkOutput("t1_mem_wen", bus.mem_wen, 1'b0);
    checkOutput("t1_busy", arb_busy, 1'b1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h00100073);
    checkOutput("t1_mem_valid_wait", bus.mem_valid, 1'b0);
    checkOutput("t1_rvalid_early", bus.if_rvalid, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t1_if_rvalid", bus.if_rvalid, 1'b1);
    checkOutput("t1_ls_rvalid", bus.ls_rvalid, 1'b0);
    checkOutput("t1_resp", bus.resp_rdata, 32'h00100073);
    checkOutput("t1_busy_idle", arb_busy, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t1_rvalid_pulse", bus.if_rvalid, 1'b0);
    checkOutput("t1_resp_hold", bus.resp_rdata, 32'h00100073);

    // 2: both valid, LS write wins, IF follows back-to-back
    applyStimulus(1, 32'h80000004, 1, 32'h80001000, 1, 32'hDEADBEEF, 4'hF, 1, 0, 0);
    checkOutput("t2_ls_ready", bus.ls_ready, 1'b1);
    checkOutput("t2_if_ready", bus.if_ready, 1'b0);
    applyStimulus(1, 32'h80000004, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("t2_mem_valid", bus.mem_valid, 1'b1);
    checkOutput("t2_mem_addr", bus.mem_addr, 32'h80001000);
    checkOutput("t2_mem_wen", bus.mem_wen, 1'b1);
    checkOutput("t2_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    checkOutput("t2_mem_wmask", bus.mem_wmask, 4'hF);
    checkOutput("t2_no_if_grant", bus.if_ready, 1'b0);
    applyStimulus(1, 32'h80000004, 0, 0, 0, 0, 0, 0, 1, 32'h0);
    applyStimulus(1, 32'h80000004, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("t2_ls_ack", bus.ls_rvalid, 1'b1);
    checkOutput("t2_if_ready_next", bus.if_ready, 1'b1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("t2_if_addr", bus.mem_addr, 32'h80000004);
    checkOutput("t2_if_payload", {bus.mem_wen, bus.mem_wdata, bus.mem_wmask}, 37'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h12345678);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t2_if_rvalid", bus.if_rvalid, 1'b1);
    checkOutput("t2_resp", bus.resp_rdata, 32'h12345678);

    // 3: both held high, 12 requests rotate LS x4 then IF
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1, 32'h80000100, 1, 32'h80003000, 1, 32'h1000 + k, 4'hF, 1, 0, 0);
      expLs = ((k % 5) != 4);
      checkOutput($sformatf("t3_ls_grant%0d", k), bus.ls_ready, expLs);
      checkOutput($sformatf("t3_if_grant%0d", k), bus.if_ready, !expLs);
      if (k > 0) begin
        checkOutput($sformatf("t3_rvalid%0d", k - 1), {bus.if_rvalid, bus.ls_rvalid},
                    prevLs ? 2'b01 : 2'b10);
        checkOutput($sformatf("t3_resp%0d", k - 1), bus.resp_rdata, 32'hA000 + k - 1);
      end
      applyStimulus(1, 32'h80000100, 1, 32'h80003000, 1, 32'h1000 + k, 4'hF, 1, 0, 0);
      checkOutput($sformatf("t3_mem_wen%0d", k), bus.mem_wen, expLs);
      applyStimulus(1, 32'h80000100, 1, 32'h80003000, 1, 32'h1000 + k, 4'hF, 1, 1, 32'hA000 + k);
      prevLs = expLs;
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t3_rvalid_last", {bus.if_rvalid, bus.ls_rvalid}, 2'b01);
    checkOutput("t3_resp_last", bus.resp_rdata, 32'hA00B);

    // 4: memory stalls for 5 cycles in ISSUE
    applyStimulus(0, 0, 1, 32'h80002000, 0, 32'h11111111, 4'h3, 0, 0, 0);
    checkOutput("t4_ls_ready", bus.ls_ready, 1'b1);
    for (int s = 0; s < 5; s++) begin
      applyStimulus(1, 32'h80000200, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput($sformatf("t4_valid%0d", s), bus.mem_valid, 1'b1);
      checkOutput($sformatf("t4_payload%0d", s), {bus.mem_addr, bus.mem_wen, bus.mem_wmask},
                  {32'h80002000, 1'b0, 4'h3});
      checkOutput($sformatf("t4_no_grant%0d", s), {bus.if_ready, bus.ls_ready}, 2'b00);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("t4_valid_accept", bus.mem_valid, 1'b1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D);
    checkOutput("t4_valid_wait", bus.mem_valid, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t4_ls_rvalid", bus.ls_rvalid, 1'b1);
    checkOutput("t4_resp", bus.resp_rdata, 32'hCAFEF00D);

    // Stray memory response while IDLE is ignored
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h55555555);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("stray_rvalid", {bus.if_rvalid, bus.ls_rvalid, arb_busy}, 3'b000);
    checkOutput("stray_resp", bus.resp_rdata, 32'hCAFEF00D);

    // 5: reset during WAIT
    applyStimulus(1, 32'h80000300, 0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t5_busy_wait", arb_busy, 1'b1);
    rst = 1'b0;
    #1;
    checkAllZero("t5_reset");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    for (int r = 0; r < 2; r++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput($sformatf("t5_quiet%0d", r), {bus.if_rvalid, bus.ls_rvalid, arb_busy}, 3'b000);
    end
    applyStimulus(1, 32'h80000400, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("t5_if_ready", bus.if_ready, 1'b1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("t5_mem_addr", bus.mem_addr, 32'h80000400);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h00000013);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t5_if_rvalid", bus.if_rvalid, 1'b1);
    checkOutput("t5_resp", bus.resp_rdata, 32'h00000013);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule
